// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCheck,
    StDone,
    StError
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [7:0]  CSUM_INIT      = 8'h00;

endpackage

// File: rtl/imem_word_packer.sv
// Packs little-endian bytes into 32-bit words; word_valid marks the 4th byte.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  cnt_q;
  logic [23:0] asm_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (byte_valid) begin
      cnt_q <= cnt_q + 2'd1;
      unique case (cnt_q)
        2'd0:    asm_q[7:0]   <= byte_data;
        2'd1:    asm_q[15:8]  <= byte_data;
        2'd2:    asm_q[23:16] <= byte_data;
        default: asm_q        <= '0;
      endcase
    end
  end

  // The top byte bypasses the register so the word is complete on the 4th transfer.
  assign word_valid = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_data  = {byte_data, asm_q};

endmodule

// File: rtl/imem_loader.sv
// Parses a framed program image (length, words, XOR checksum) into instruction memory
// and holds the core in reset until the image is verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 128,
  parameter int unsigned LEN_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_adr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q;
  logic [7:0]        csum_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_full;
  logic [IdxW-1:0]   word_idx_q;
  logic [31:0]       wr_adr_q, wr_data_q;
  logic              wr_en_q;
  logic              xfer, start_frame, byte_valid, word_valid, last_word;
  logic [31:0]       word_data;

  assign xfer        = in_valid && in_ready;
  assign len_full    = LEN_W'({in_data, len_lo_q});
  assign start_frame = start && (state_q inside {StIdle, StDone, StError});
  assign byte_valid  = xfer && (state_q == StData);
  assign last_word   = (32'(word_idx_q) + 32'd1) == 32'(len_q);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_frame),
    .byte_valid (byte_valid),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLenLo;
      StLenLo: if (xfer) state_d = StLenHi;
      StLenHi: begin
        if (xfer) begin
          if (32'(len_full) > MEM_WORDS) state_d = StError;
          else if (len_full == '0)       state_d = StCheck;
          else                           state_d = StData;
        end
      end
      StData:  if (word_valid && last_word) state_d = StCheck;
      StCheck: if (xfer) state_d = (in_data == csum_q) ? StDone : StError;
      StDone, StError: if (start) state_d = StLenLo;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      StLenLo, StLenHi, StData, StCheck: in_ready = 1'b1;
      StDone: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      StError: error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_q   <= '0;
      len_q      <= '0;
      csum_q     <= CSUM_INIT;
      word_idx_q <= '0;
      wr_en_q    <= 1'b0;
      wr_adr_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (start_frame) begin
        csum_q     <= CSUM_INIT;
        word_idx_q <= '0;
      end
      if (xfer && state_q == StLenLo) len_lo_q <= in_data;
      if (xfer && state_q == StLenHi) len_q    <= len_full;
      if (byte_valid) csum_q <= csum_q ^ in_data;
      if (word_valid) begin
        wr_en_q   <= 1'b1;
        wr_data_q <= word_data;
        wr_adr_q  <= 32'(word_idx_q) << 2;
        // Hold the index on the final word so it never wraps past the memory.
        if (!last_word) word_idx_q <= word_idx_q + 1'b1;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_adr  = wr_adr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frame table, corner sequences, random frames.
module tb_imem_loader;

  localparam int MEM_WORDS = 128;
  localparam int BUDGET    = 50;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, cpu_hold, done, error;
  logic [31:0] wr_adr, wr_data;

  always #5 clk = ~clk;

  imem_loader #(
    .MEM_WORDS (MEM_WORDS),
    .LEN_W     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_adr   (wr_adr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    string name;
    int    kind;
    int    gap;
    int    exp_writes;
    bit    exp_done;
    bit    exp_error;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  wr_t         got_q[$];
  int          xfer_log[$];
  logic [7:0]  stream[$];
  logic [31:0] exp_adr[$];
  logic [31:0] exp_data[$];
  bit          m_done, m_error;
  vec_t        vecs[6];
  logic [7:0]  nom[15] = '{8'h03, 8'h00, 8'h13, 8'h05, 8'h40, 8'h06, 8'h93, 8'h05,
                           8'hA0, 8'h00, 8'h23, 8'h20, 8'hB5, 8'h00, 8'hD0};

  always @(posedge clk) begin
    if (in_valid && in_ready) xfer_log.push_back(cyc);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (wr_en) got_q.push_back('{adr: wr_adr, data: wr_data, cyc: cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    check({name, "_wr_en"},    32'(wr_en),    32'd0);
    check({name, "_wr_adr"},   wr_adr,        32'd0);
    check({name, "_wr_data"},  wr_data,       32'd0);
    check({name, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({name, "_done"},     32'(done),     32'd0);
    check({name, "_error"},    32'(error),    32'd0);
  endtask

  task automatic build_stream(input int kind);
    int         n;
    logic [7:0] b, cs;
    stream.delete();
    case (kind)
      0, 4: foreach (nom[i]) stream.push_back(nom[i]);
      1: begin
        foreach (nom[i]) stream.push_back(nom[i]);
        stream[14] = 8'hD1;
      end
      2: begin
        stream.push_back(8'h81);
        stream.push_back(8'h00);
      end
      3: repeat (3) stream.push_back(8'h00);
      default: begin
        n = (kind == 5) ? MEM_WORDS : int'($urandom_range(0, 6));
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        cs = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
          b = 8'($urandom);
          stream.push_back(b);
          cs = cs ^ b;
        end
        if (kind != 5 && $urandom_range(0, 3) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
        stream.push_back(cs);
      end
    endcase
  endtask

  // Reference: decode the frame directly into the list of writes and the final verdict.
  task automatic model_frame();
    int         n;
    logic [7:0] cs;
    exp_adr.delete();
    exp_data.delete();
    m_done  = 1'b0;
    m_error = 1'b0;
    n = int'({stream[1], stream[0]});
    if (n > MEM_WORDS) begin
      m_error = 1'b1;
      return;
    end
    cs = 8'h00;
    for (int w = 0; w < n; w++) begin
      exp_adr.push_back(32'(4 * w));
      exp_data.push_back({stream[2+4*w+3], stream[2+4*w+2], stream[2+4*w+1], stream[2+4*w]});
      for (int j = 0; j < 4; j++) cs = cs ^ stream[2+4*w+j];
    end
    m_done  = (stream[2+4*n] == cs);
    m_error = !m_done;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, inout int stalls);
    int k;
    repeat ($urandom_range(0, gap)) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    if (k == BUDGET) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: in_ready low for %0d cycles, expected 1", k);
    end
    stalls += k;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // start_at >= 0 injects a start pulse (with in_valid low) before that byte index.
  task automatic run_frame(input string name, input int gap, input int exp_writes,
                           input bit exp_done, input bit exp_error, input int start_at);
    int stalls;
    int idx;
    stalls = 0;
    start_pulse();
    check({name, "_ready_after_start"}, 32'(in_ready), 32'd1);
    check({name, "_hold_after_start"},  32'(cpu_hold), 32'd1);
    got_q.delete();
    xfer_log.delete();
    for (int i = 0; i < stream.size(); i++) begin
      if (i == start_at) start_pulse();
      send_byte(stream[i], gap, stalls);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_done"},     32'(done),     32'(exp_done));
    check({name, "_error"},    32'(error),    32'(exp_error));
    check({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check({name, "_n_writes"}, 32'(got_q.size()), 32'(exp_writes));
    for (int i = 0; i < got_q.size() && i < exp_adr.size(); i++) begin
      check({name, "_adr"},  got_q[i].adr,  exp_adr[i]);
      check({name, "_data"}, got_q[i].data, exp_data[i]);
      idx = 2 + 4 * i + 3;
      if (idx < xfer_log.size())
        check({name, "_latency"}, 32'(got_q[i].cyc), 32'(xfer_log[idx] + 1));
    end
    if (gap == 0 && start_at < 0) check({name, "_no_bubbles"}, 32'(stalls), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    vecs[0] = '{"nominal",  0, 0, 3,   1'b1, 1'b0};
    vecs[1] = '{"bad_csum", 1, 0, 3,   1'b0, 1'b1};
    vecs[2] = '{"oversize", 2, 0, 0,   1'b0, 1'b1};
    vecs[3] = '{"empty",    3, 0, 0,   1'b1, 1'b0};
    vecs[4] = '{"gaps",     4, 3, 3,   1'b1, 1'b0};
    vecs[5] = '{"full",     5, 0, 128, 1'b1, 1'b0};
    foreach (vecs[v]) begin
      build_stream(vecs[v].kind);
      model_frame();
      run_frame(vecs[v].name, vecs[v].gap, vecs[v].exp_writes, vecs[v].exp_done,
                vecs[v].exp_error, -1);
    end

    // A start pulse mid-payload must not restart the frame.
    stream.delete();
    stream = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    model_frame();
    run_frame("start_in_data", 0, 1, 1'b1, 1'b0, 4);

    // Reset after six payload bytes: one write, nothing more, then a clean reload.
    build_stream(0);
    start_pulse();
    got_q.delete();
    stalls = 0;
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0, stalls);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    check("mid_rst_writes", 32'(got_q.size()), 32'd1);
    repeat (5) @(negedge clk);
    check("mid_rst_writes_later", 32'(got_q.size()), 32'd1);
    model_frame();
    run_frame("after_rst", 0, 3, 1'b1, 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      build_stream(6);
      model_frame();
      run_frame("rand", int'($urandom_range(0, 3)), exp_adr.size(), m_done, m_error, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the writable instruction memory of the single-cycle RISC-V core from a byte stream (UART receiver or test bench). It parses a small framed image (length header, little-endian instruction words, XOR checksum) and drives the memory write port with word-aligned byte addresses, the same `adr[31:2]` word indexing the fetch side uses. It holds the core in reset until the image is loaded and verified.

## Interface
- `MEM_WORDS`, 128: instruction memory capacity in 32-bit words.
- `LEN_W`, 16: width of the length header, in bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs on an edge with `in_valid && in_ready`.
- `wr_en`  out  1  one-cycle instruction memory write strobe.
- `wr_adr`  out  32  byte address, always a multiple of 4 (`word_idx*4`).
- `wr_data`  out  32  instruction word.
- `cpu_hold`  out  1  core reset/stall request.
- `done`  out  1  image loaded and checksum matched.
- `error`  out  1  oversize image or checksum mismatch.

## Operation
- Frame format: `LEN_LO`, `LEN_HI` (word count N, little-endian), 4·N payload bytes (each word LSB first), then one checksum byte equal to the XOR of all payload bytes. The length bytes are not included in the checksum.
- States:
  - IDLE: `start` → LEN_LO.
  - LEN_LO: on transfer → LEN_HI.
  - LEN_HI: on transfer, evaluate N:
    - N > `MEM_WORDS` → ERROR.
    - N == 0 → CHECK.
    - otherwise → DATA.
  - DATA: after the 4th byte of word N−1 → CHECK.
  - CHECK: on transfer, byte == running XOR → DONE, else → ERROR.
  - DONE and ERROR: `start` → LEN_LO.
- `in_ready` = 1 only in LEN_LO, LEN_HI, DATA and CHECK. It is decoded from the registered state.
- DATA:
  - A 2-bit byte counter shifts bytes into an assembly register at bit positions `[8k+7:8k]`.
  - On the 4th byte, the completed word and `word_idx*4` are latched into `wr_data`/`wr_adr`, `wr_en` is set for exactly one cycle, and `word_idx` increments.
  - Byte 0 of the next word may be accepted in that same `wr_en` cycle; the write registers stay stable.
- The running XOR and `word_idx` clear on entry to LEN_LO.
- `cpu_hold` = 0 only in DONE. It re-asserts immediately on `start` from DONE.
- `done` = 1 only in DONE; `error` = 1 only in ERROR.
- `start` in LEN_LO, LEN_HI, DATA or CHECK is ignored.
- Words beyond N are never written. `word_idx` never exceeds `MEM_WORDS`−1.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=0, `wr_en`=0, `wr_adr`=0, `wr_data`=0.
  - `cpu_hold`=1, `done`=0, `error`=0.
  - byte counter, `word_idx` and XOR all 0.
- `rst` mid-load aborts the frame. No further `wr_en` is issued, and partially assembled bytes are discarded.
- Write latency: `wr_en` is high on the cycle after the edge that transfers the 4th byte of a word.
- `done`/`error` assert on the cycle after the checksum transfer, or after the LEN_HI transfer for an oversize image.
- Throughput: one byte per cycle, with no bubbles, including across word boundaries.
- With `in_valid` low, the state and counters hold indefinitely. There is no timeout.

## Structure
- `imem_loader_pkg` holds:
  - state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR);
  - `BYTES_PER_WORD`=4;
  - the checksum reset constant 8'h00.
- Sub-module `imem_word_packer`: byte counter plus assembly register. Signals `word_valid` on the 4th byte and clears on `rst` or on frame start.
- The FSM, length/index counters, XOR and output registers live in `imem_loader`.

## Test plan
- Nominal load: stream 03 00 13 05 40 06 93 05 A0 00 23 20 B5 00 D0.
  - Three `wr_en` pulses: (0x0, 0x06400513), (0x4, 0x00A00593), (0x8, 0x00B52023).
  - Then `done`=1 and `cpu_hold`=0.
- Bad checksum: same stream with last byte D1 → same three writes, then `error`=1, `cpu_hold`=1, `in_ready`=0.
- Oversize: length 81 00 (N=129) → `error` the cycle after LEN_HI, with zero writes.
- Backpressure and gaps: random `in_valid` gaps in the nominal stream → identical writes, and no write occurs without a completed word.
- Reset mid-DATA: `rst` after 6 payload bytes → no second write. Outputs return to reset values. A subsequent `start` plus the nominal stream loads correctly from address 0.
- Empty image: 00 00 00 → zero writes, `done`=1. A `start` pulse during DATA is ignored (no state change).
